prbs_burst_checker: RTL and testbench

Receive-side counterpart of the PON PRBS burst generator. Consumes a 32-bit AXI-Stream of bursts (repeated preamble words, optional delimiter, PRBS31 payload, TLAST on the final payload word) from the transceiver RX user-data path. Locates each burst, validates preamble and delimiter, seeds a PRBS31 reference from the first payload word, and accumulates bit/word error and burst statistics for VIO/ILA readout.

---
 rtl/prbs_burst_checker.sv | 279 +++++++++++++++++++++++++++
 tb/tb_prbs_burst_checker.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_burst_checker.sv
// PRBS31 burst checker: finds preamble/delimiter framed bursts on a 32-bit
// AXI-Stream, seeds a PRBS31 reference from the first payload word and keeps
// saturating bit/word/frame error and burst statistics.
module prbs_burst_checker #(
   parameter logic [31:0] PREAMBLE  = 32'h05560556,
   parameter logic [31:0] DELIMITER = 32'hB2C50FA1
) (
   input  logic        rx_axis_usrclk,
   input  logic        reset_in,
   input  logic [31:0] s_axis_TDATA,
   input  logic        s_axis_TVALID,
   input  logic        s_axis_TLAST,
   output logic        s_axis_TREADY,
   input  logic [31:0] preamble_length,
   input  logic        add_delimiter,
   input  logic        clear_stats,
   output logic        burst_done,
   output logic [31:0] burst_count,
   output logic [31:0] bit_err_count,
   output logic [31:0] word_err_count,
   output logic [31:0] frame_err_count,
   output logic [31:0] last_burst_words,
   output logic [31:0] last_preamble_words
);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_PRE        = 2'd1,
      ST_DELIM_WAIT = 2'd2,
      ST_CHECK      = 2'd3
   } state_t;

   // Next 32 serial PRBS31 bits after the word w (bit 31 = earliest bit).
   function automatic logic [31:0] prbs31_next(input logic [31:0] w);
      logic [63:0] seq;
      logic [31:0] nxt;
      seq = 64'd0;
      nxt = 32'd0;
      for (int j = 0; j < 32; j++) begin
         seq[j] = w[31-j];
      end
      for (int j = 32; j < 64; j++) begin
         seq[j] = seq[j-31] ^ seq[j-28];
      end
      for (int i = 0; i < 32; i++) begin
         nxt[31-i] = seq[32+i];
      end
      return nxt;
   endfunction

   // Number of set bits in a word.
   function automatic logic [5:0] popcount32(input logic [31:0] v);
      logic [5:0] cnt;
      cnt = 6'd0;
      for (int i = 0; i < 32; i++) begin
         cnt = cnt + {5'd0, v[i]};
      end
      return cnt;
   endfunction

   // Increment that sticks at all-ones.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      logic [31:0] r;
      if (v == 32'hFFFFFFFF) begin
         r = v;
      end else begin
         r = v + 32'd1;
      end
      return r;
   endfunction

   state_t      state_q, state_d;
   logic [31:0] pre_cnt_q, pre_cnt_d;
   logic [31:0] payload_cnt_q, payload_cnt_d;
   logic [31:0] ref_q, ref_d;
   logic        tready_q;
   logic        burst_done_q;
   logic [31:0] burst_count_q, burst_count_d;
   logic [31:0] bit_err_q, bit_err_d;
   logic [31:0] word_err_q, word_err_d;
   logic [31:0] frame_err_q, frame_err_d;
   logic [31:0] last_burst_q, last_burst_d;
   logic [31:0] last_pre_q, last_pre_d;

   logic        accept_s;
   logic        frame_ev_s;
   logic        check_ev_s;
   logic        done_ev_s;
   logic        seed_ev_s;
   logic        latch_pre_s;
   logic [31:0] pred_s;
   logic [31:0] diff_s;
   logic [5:0]  diff_bits_s;
   logic [32:0] bit_sum_s;

   assign accept_s    = s_axis_TVALID & tready_q;
   assign pred_s      = prbs31_next(ref_q);
   assign diff_s      = pred_s ^ s_axis_TDATA;
   assign diff_bits_s = popcount32(diff_s);
   assign bit_sum_s   = {1'b0, bit_err_q} + {27'd0, diff_bits_s};

   // Burst framing FSM: decides the per-word event for each accepted word.
   always_comb begin
      state_d     = state_q;
      pre_cnt_d   = pre_cnt_q;
      frame_ev_s  = 1'b0;
      check_ev_s  = 1'b0;
      done_ev_s   = 1'b0;
      seed_ev_s   = 1'b0;
      latch_pre_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s && (s_axis_TDATA == PREAMBLE)) begin
               state_d   = ST_PRE;
               pre_cnt_d = 32'd1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PRE: begin
            if (!accept_s) begin
               state_d = ST_PRE;
            end else if (s_axis_TLAST) begin
               frame_ev_s = 1'b1;
               state_d    = ST_IDLE;
            end else if (s_axis_TDATA == PREAMBLE) begin
               pre_cnt_d = sat_inc(pre_cnt_q);
            end else if (pre_cnt_q < preamble_length) begin
               frame_ev_s = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               latch_pre_s = 1'b1;
               if (add_delimiter) begin
                  if (s_axis_TDATA == DELIMITER) begin
                     state_d = ST_DELIM_WAIT;
                  end else begin
                     frame_ev_s = 1'b1;
                     state_d    = ST_IDLE;
                  end
               end else begin
                  seed_ev_s = 1'b1;
                  state_d   = ST_CHECK;
               end
            end
         end
         ST_DELIM_WAIT: begin
            if (!accept_s) begin
               state_d = ST_DELIM_WAIT;
            end else if (s_axis_TLAST) begin
               frame_ev_s = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               seed_ev_s = 1'b1;
               state_d   = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (!accept_s) begin
               state_d = ST_CHECK;
            end else begin
               check_ev_s = 1'b1;
               if (s_axis_TLAST) begin
                  done_ev_s = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  state_d = ST_CHECK;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Reference generator and payload word counter; the reference free-runs on predictions.
   always_comb begin
      ref_d         = ref_q;
      payload_cnt_d = payload_cnt_q;
      if (seed_ev_s) begin
         ref_d         = s_axis_TDATA;
         payload_cnt_d = 32'd1;
      end else if (check_ev_s) begin
         ref_d         = pred_s;
         payload_cnt_d = sat_inc(payload_cnt_q);
      end else begin
         ref_d         = ref_q;
         payload_cnt_d = payload_cnt_q;
      end
   end

   // Statistics update; clear_stats overrides any same-cycle increment.
   always_comb begin
      burst_count_d = burst_count_q;
      bit_err_d     = bit_err_q;
      word_err_d    = word_err_q;
      frame_err_d   = frame_err_q;
      last_burst_d  = last_burst_q;
      last_pre_d    = last_pre_q;
      if (clear_stats) begin
         burst_count_d = 32'd0;
         bit_err_d     = 32'd0;
         word_err_d    = 32'd0;
         frame_err_d   = 32'd0;
         last_burst_d  = 32'd0;
         last_pre_d    = 32'd0;
      end else begin
         if (frame_ev_s) begin
            frame_err_d = sat_inc(frame_err_q);
         end else begin
            frame_err_d = frame_err_q;
         end
         if (latch_pre_s) begin
            last_pre_d = pre_cnt_q;
         end else begin
            last_pre_d = last_pre_q;
         end
         if (check_ev_s) begin
            bit_err_d = bit_sum_s[32] ? 32'hFFFFFFFF : bit_sum_s[31:0];
            if (diff_s != 32'd0) begin
               word_err_d = sat_inc(word_err_q);
            end else begin
               word_err_d = word_err_q;
            end
         end else begin
            bit_err_d  = bit_err_q;
            word_err_d = word_err_q;
         end
         if (done_ev_s) begin
            burst_count_d = sat_inc(burst_count_q);
            last_burst_d  = sat_inc(payload_cnt_q);
         end else begin
            burst_count_d = burst_count_q;
            last_burst_d  = last_burst_q;
         end
      end
   end

   // State, datapath and statistic registers with synchronous reset.
   always_ff @(posedge rx_axis_usrclk) begin
      if (reset_in) begin
         state_q       <= ST_IDLE;
         pre_cnt_q     <= 32'd0;
         payload_cnt_q <= 32'd0;
         ref_q         <= 32'd0;
         tready_q      <= 1'b0;
         burst_done_q  <= 1'b0;
         burst_count_q <= 32'd0;
         bit_err_q     <= 32'd0;
         word_err_q    <= 32'd0;
         frame_err_q   <= 32'd0;
         last_burst_q  <= 32'd0;
         last_pre_q    <= 32'd0;
      end else begin
         state_q       <= state_d;
         pre_cnt_q     <= pre_cnt_d;
         payload_cnt_q <= payload_cnt_d;
         ref_q         <= ref_d;
         tready_q      <= 1'b1;
         burst_done_q  <= done_ev_s;
         burst_count_q <= burst_count_d;
         bit_err_q     <= bit_err_d;
         word_err_q    <= word_err_d;
         frame_err_q   <= frame_err_d;
         last_burst_q  <= last_burst_d;
         last_pre_q    <= last_pre_d;
      end
   end

   assign s_axis_TREADY       = tready_q;
   assign burst_done          = burst_done_q;
   assign burst_count         = burst_count_q;
   assign bit_err_count       = bit_err_q;
   assign word_err_count      = word_err_q;
   assign frame_err_count     = frame_err_q;
   assign last_burst_words    = last_burst_q;
   assign last_preamble_words = last_pre_q;

endmodule

// File: tb/tb_prbs_burst_checker.sv
// Directed bench for prbs_burst_checker: table of burst scenarios plus
// hand-written sequences for gaps, clear/done collision and mid-burst reset.
module tb_prbs_burst_checker;

   localparam logic [31:0] PRE   = 32'h05560556;
   localparam logic [31:0] DELIM = 32'hB2C50FA1;

   logic        clk;
   logic        reset_in;
   logic [31:0] tdata;
   logic        tvalid;
   logic        tlast;
   logic        tready;
   logic [31:0] preamble_length;
   logic        add_delimiter;
   logic        clear_stats;
   logic        burst_done;
   logic [31:0] burst_count;
   logic [31:0] bit_err_count;
   logic [31:0] word_err_count;
   logic [31:0] frame_err_count;
   logic [31:0] last_burst_words;
   logic [31:0] last_preamble_words;

   prbs_burst_checker dut (
      .rx_axis_usrclk     (clk),
      .reset_in           (reset_in),
      .s_axis_TDATA       (tdata),
      .s_axis_TVALID      (tvalid),
      .s_axis_TLAST       (tlast),
      .s_axis_TREADY      (tready),
      .preamble_length    (preamble_length),
      .add_delimiter      (add_delimiter),
      .clear_stats        (clear_stats),
      .burst_done         (burst_done),
      .burst_count        (burst_count),
      .bit_err_count      (bit_err_count),
      .word_err_count     (word_err_count),
      .frame_err_count    (frame_err_count),
      .last_burst_words   (last_burst_words),
      .last_preamble_words(last_preamble_words)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int done_total = 0;
   int tready_bad = 0;
   bit gap_en = 1'b0;
   bit clr_on_last = 1'b0;
   logic [31:0] pay [0:255];

   always @(negedge clk) begin
      if (burst_done === 1'b1) done_total++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
   endtask

   // PRBS31 reference as a serial 31-bit history window: win[k] = s[n-1-k].
   task automatic gen(input logic [31:0] seed, input int n);
      logic [30:0] win;
      logic [31:0] w;
      logic        nb;
      pay[0] = seed;
      win = seed[30:0];
      for (int k = 1; k < n; k++) begin
         w = 32'd0;
         for (int b = 0; b < 32; b++) begin
            nb = win[30] ^ win[27];
            w[31-b] = nb;
            win = {win[29:0], nb};
         end
         pay[k] = w;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         tvalid = 1'b0;
         tlast = 1'b0;
         clear_stats = 1'b0;
      end
   endtask

   task automatic put(input logic [31:0] d, input logic l);
      if (gap_en) begin
         for (int g = 0; g < 4; g++) begin
            if ($urandom_range(1, 0) == 1) begin
               @(negedge clk);
               tvalid = 1'b0;
               tlast = 1'b0;
               if (tready !== 1'b1) tready_bad++;
            end
         end
      end
      @(negedge clk);
      if (gap_en && tready !== 1'b1) tready_bad++;
      tdata = d;
      tlast = l;
      tvalid = 1'b1;
      clear_stats = clr_on_last && l;
   endtask

   task automatic burst(input int npre, input logic adel, input logic [31:0] delim,
                        input int npay, input logic [31:0] seed, input int last_pre,
                        input int e1i, input logic [31:0] e1m,
                        input int e2i, input logic [31:0] e2m);
      logic [31:0] w;
      for (int i = 0; i < npre; i++) begin
         if (i == last_pre) begin
            put(PRE, 1'b1);
            return;
         end
         put(PRE, 1'b0);
      end
      if (adel) put(delim, 1'b0);
      gen(seed, npay);
      for (int k = 0; k < npay; k++) begin
         w = pay[k];
         if (k == e1i) w = w ^ e1m;
         if (k == e2i) w = w ^ e2m;
         put(w, k == npay - 1);
      end
   endtask

   task automatic clear_pulse();
      @(negedge clk);
      tvalid = 1'b0;
      tlast = 1'b0;
      clear_stats = 1'b1;
      @(negedge clk);
      clear_stats = 1'b0;
   endtask

   typedef struct {
      logic [31:0] plen;
      logic        adel;
      int          npre;
      logic [31:0] delim;
      int          npay;
      int          last_pre;
      int          e1i;
      logic [31:0] e1m;
      int          e2i;
      logic [31:0] e2m;
      bit          clr;
      int          bc, fe, be, we, lbw, lpw, done;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int d0;
      vecs[0] = '{32'd4, 1'b0, 6, DELIM, 100, -1, -1, 32'd0, -1, 32'd0, 1'b1, 1, 0, 0, 0, 100, 6, 1};
      vecs[1] = '{32'd4, 1'b1, 8, DELIM, 50, -1, -1, 32'd0, -1, 32'd0, 1'b1, 1, 0, 0, 0, 50, 8, 1};
      vecs[2] = '{32'd4, 1'b1, 8, 32'hB2C50FA0, 50, -1, -1, 32'd0, -1, 32'd0, 1'b1, 0, 1, 0, 0, 0, -1, 0};
      vecs[3] = '{32'd4, 1'b0, 6, DELIM, 100, -1, 10, 32'h80000001, 20, 32'h00000020, 1'b1, 1, 0, 3, 2, 100, 6, 1};
      vecs[4] = '{32'd8, 1'b0, 3, DELIM, 20, -1, -1, 32'd0, -1, 32'd0, 1'b1, 0, 1, 0, 0, 0, 0, 0};
      vecs[5] = '{32'd8, 1'b0, 2, DELIM, 20, 1, -1, 32'd0, -1, 32'd0, 1'b0, 0, 2, 0, 0, 0, 0, 0};
      vecs[6] = '{32'd4, 1'b0, 5, DELIM, 1, -1, -1, 32'd0, -1, 32'd0, 1'b1, 0, 1, 0, 0, 0, -1, 0};
      vecs[7] = '{32'd1, 1'b0, 1, DELIM, 2, -1, -1, 32'd0, -1, 32'd0, 1'b1, 1, 0, 0, 0, 2, 1, 1};
      vecs[8] = '{32'd4, 1'b1, 4, DELIM, 1, -1, -1, 32'd0, -1, 32'd0, 1'b1, 0, 1, 0, 0, 0, -1, 0};

      reset_in = 1'b1;
      tdata = 32'd0;
      tvalid = 1'b0;
      tlast = 1'b0;
      preamble_length = 32'd4;
      add_delimiter = 1'b0;
      clear_stats = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tready", {31'd0, tready}, 32'd0);
      check("rst_done", {31'd0, burst_done}, 32'd0);
      check("rst_burst_count", burst_count, 32'd0);
      check("rst_bit_err", bit_err_count, 32'd0);
      check("rst_frame_err", frame_err_count, 32'd0);
      check("rst_last_pre", last_preamble_words, 32'd0);
      reset_in = 1'b0;
      @(negedge clk);
      check("tready_after_rst", {31'd0, tready}, 32'd1);

      // Hand-computed PRBS31 step: seed 1 is followed by 32'h00000012.
      burst(4, 1'b0, DELIM, 0, 32'd0, -1, -1, 32'd0, -1, 32'd0);
      put(32'h00000001, 1'b0);
      put(32'h00000012, 1'b1);
      idle(3);
      check("hand_prbs_bit_err", bit_err_count, 32'd0);
      check("hand_prbs_bursts", burst_count, 32'd1);
      check("hand_prbs_words", last_burst_words, 32'd2);

      for (int i = 0; i < 9; i++) begin
         if (vecs[i].clr) clear_pulse();
         preamble_length = vecs[i].plen;
         add_delimiter = vecs[i].adel;
         d0 = done_total;
         burst(vecs[i].npre, vecs[i].adel, vecs[i].delim, vecs[i].npay,
               32'h13579BDF ^ 32'(i), vecs[i].last_pre,
               vecs[i].e1i, vecs[i].e1m, vecs[i].e2i, vecs[i].e2m);
         idle(3);
         check($sformatf("v%0d_burst_count", i), burst_count, 32'(vecs[i].bc));
         check($sformatf("v%0d_frame_err", i), frame_err_count, 32'(vecs[i].fe));
         check($sformatf("v%0d_bit_err", i), bit_err_count, 32'(vecs[i].be));
         check($sformatf("v%0d_word_err", i), word_err_count, 32'(vecs[i].we));
         check($sformatf("v%0d_last_burst", i), last_burst_words, 32'(vecs[i].lbw));
         if (vecs[i].lpw >= 0) check($sformatf("v%0d_last_pre", i), last_preamble_words, 32'(vecs[i].lpw));
         check($sformatf("v%0d_done_pulses", i), 32'(done_total - d0), 32'(vecs[i].done));
      end

      // Three back-to-back bursts with random TVALID gaps.
      clear_pulse();
      preamble_length = 32'd4;
      add_delimiter = 1'b0;
      gap_en = 1'b1;
      d0 = done_total;
      for (int b = 0; b < 3; b++) begin
         burst(4, 1'b0, DELIM, 64, 32'h2468ACE1 + 32'(b), -1, -1, 32'd0, -1, 32'd0);
      end
      gap_en = 1'b0;
      idle(3);
      check("gap_burst_count", burst_count, 32'd3);
      check("gap_bit_err", bit_err_count, 32'd0);
      check("gap_word_err", word_err_count, 32'd0);
      check("gap_frame_err", frame_err_count, 32'd0);
      check("gap_last_burst", last_burst_words, 32'd64);
      check("gap_done_pulses", 32'(done_total - d0), 32'd3);
      check("gap_tready_low", 32'(tready_bad), 32'd0);

      // clear_stats on the same word as TLAST: clear wins.
      clear_pulse();
      clr_on_last = 1'b1;
      burst(4, 1'b0, DELIM, 10, 32'h0BADF00D, -1, 9, 32'h00000001, -1, 32'd0);
      clr_on_last = 1'b0;
      idle(3);
      check("clr_burst_count", burst_count, 32'd0);
      check("clr_bit_err", bit_err_count, 32'd0);
      check("clr_word_err", word_err_count, 32'd0);
      check("clr_last_burst", last_burst_words, 32'd0);
      check("clr_last_pre", last_preamble_words, 32'd0);

      // Reset in the middle of the payload drops the burst silently.
      for (int i = 0; i < 4; i++) put(PRE, 1'b0);
      gen(32'h55AA1234, 8);
      put(pay[0], 1'b0);
      put(pay[1] ^ 32'h00000003, 1'b0);
      put(pay[2], 1'b0);
      idle(1);
      check("pre_rst_bit_err", bit_err_count, 32'd2);
      @(negedge clk);
      reset_in = 1'b1;
      tvalid = 1'b0;
      @(negedge clk);
      check("mid_rst_tready", {31'd0, tready}, 32'd0);
      reset_in = 1'b0;
      @(negedge clk);
      check("post_rst_tready", {31'd0, tready}, 32'd1);
      check("post_rst_bit_err", bit_err_count, 32'd0);
      check("post_rst_word_err", word_err_count, 32'd0);
      check("post_rst_frame_err", frame_err_count, 32'd0);
      burst(4, 1'b0, DELIM, 20, 32'h7654FEDC, -1, -1, 32'd0, -1, 32'd0);
      idle(3);
      check("after_rst_burst_count", burst_count, 32'd1);
      check("after_rst_last_burst", last_burst_words, 32'd20);
      check("after_rst_bit_err", bit_err_count, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
